// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_bus_arbiter_if: requester and SPI-master signals of the arbiter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface spi_bus_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic              start0;
  logic              cs_end0;
  logic [DATA_W-1:0] mosi0;
  logic              grant0;
  logic              busy0;

  logic              req1;
  logic              start1;
  logic              cs_end1;
  logic [DATA_W-1:0] mosi1;
  logic              grant1;
  logic              busy1;

  logic [DATA_W-1:0] miso;
  logic              spi_start;
  logic              spi_cs_end;
  logic [DATA_W-1:0] spi_mosi;
  logic              spi_busy;
  logic [DATA_W-1:0] spi_miso;
  logic              drop_err;

  // master: the arbiter itself; slave: the requesters plus the SPI master
  modport master (
    input  req0, start0, cs_end0, mosi0,
    input  req1, start1, cs_end1, mosi1,
    input  spi_busy, spi_miso,
    output grant0, busy0, grant1, busy1,
    output miso, spi_start, spi_cs_end, spi_mosi, drop_err
  );

  modport slave (
    output req0, start0, cs_end0, mosi0,
    output req1, start1, cs_end1, mosi1,
    output spi_busy, spi_miso,
    input  grant0, busy0, grant1, busy1,
    input  miso, spi_start, spi_cs_end, spi_mosi, drop_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_bus_arbiter: round-robin sharing of one SPI master between two  |
// | requesters, switching owners only at chip-select boundaries.        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spi_bus_arbiter #(
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 1000,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_bus_arbiter_if.master      bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  state_t           r_state;
  logic             r_owner;
  logic             r_last_owner;
  logic             r_grant0;
  logic             r_grant1;
  logic             r_cs_open;
  logic             r_drop_err;
  logic [CNT_W-1:0] r_hold_cnt;

  logic              w_owned;
  logic              w_req_own;
  logic              w_req_oth;
  logic              w_start_own;
  logic              w_cs_end_own;
  logic [DATA_W-1:0] w_mosi_own;
  logic              w_spi_start;
  logic              w_cs_boundary;
  logic              w_drop;
  logic              w_pick;

  assign w_owned      = (r_state == ST_OWNED);
  assign w_req_own    = r_owner ? bus.req1    : bus.req0;
  assign w_req_oth    = r_owner ? bus.req0    : bus.req1;
  assign w_start_own  = r_owner ? bus.start1  : bus.start0;
  assign w_cs_end_own = r_owner ? bus.cs_end1 : bus.cs_end0;
  assign w_mosi_own   = r_owner ? bus.mosi1   : bus.mosi0;

  assign w_spi_start   = w_owned & w_start_own & ~bus.spi_busy;
  assign w_cs_boundary = ~r_cs_open & ~bus.spi_busy & ~w_spi_start;

  // A start is dropped if it comes from the non-owner or hits a busy master
  assign w_drop = (bus.start0 & ~r_grant0) | (bus.start1 & ~r_grant1) |
                  (w_owned & w_start_own & bus.spi_busy);

  // On a tie the requester that did not own the bus last wins
  assign w_pick = (bus.req0 & bus.req1) ? ~r_last_owner : bus.req1;

  assign bus.spi_start  = w_spi_start;
  assign bus.spi_cs_end = w_owned ? w_cs_end_own : 1'b1;
  assign bus.spi_mosi   = w_owned ? w_mosi_own : '0;
  assign bus.miso       = bus.spi_miso;
  assign bus.grant0     = r_grant0;
  assign bus.grant1     = r_grant1;
  assign bus.busy0      = r_grant0 ? bus.spi_busy : 1'b1;
  assign bus.busy1      = r_grant1 ? bus.spi_busy : 1'b1;
  assign bus.drop_err   = r_drop_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_grant0     <= 1'b0;
      r_grant1     <= 1'b0;
      r_cs_open    <= 1'b0;
      r_drop_err   <= 1'b0;
      r_hold_cnt   <= '0;
    end else begin
      if (w_drop) begin
        r_drop_err <= 1'b1;
      end
      if (w_spi_start) begin
        r_cs_open <= ~w_cs_end_own;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.req0 | bus.req1) begin
            r_owner    <= w_pick;
            r_grant0   <= ~w_pick;
            r_grant1   <= w_pick;
            r_hold_cnt <= '0;
            r_state    <= ST_OWNED;
          end
        end

        ST_OWNED: begin
          // An open frame (cs_open) blocks both voluntary and forced release
          if (w_cs_boundary && !w_req_own) begin
            r_state      <= ST_GAP;
            r_grant0     <= 1'b0;
            r_grant1     <= 1'b0;
            r_last_owner <= r_owner;
            r_hold_cnt   <= '0;
          end else if (w_cs_boundary && w_req_oth) begin
            if (r_hold_cnt == C_HOLD_LAST) begin
              r_state      <= ST_GAP;
              r_grant0     <= 1'b0;
              r_grant1     <= 1'b0;
              r_last_owner <= r_owner;
              r_hold_cnt   <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
          end else if (w_spi_start || !w_req_oth) begin
            r_hold_cnt <= '0;
          end
        end

        ST_GAP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
